// File: rtl/addacc_t1ff_chain.sv
// addacc_t1ff_chain: cycle-based T1 flip-flop cascade used as a pulse accumulator with X tracking
module addacc_t1ff_chain #(
    parameter int WIDTH       = 4,
    parameter int STAGE_DELAY = 2,
    parameter int T_SEP       = 2,
    parameter int HS_WIN      = 3,
    parameter int RD_DELAY    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t,
    input  logic             wr0,
    output logic             carry_out,
    output logic             carry_out_x,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd1_x,
    output logic             rd1_valid,
    output logic             sep_err,
    output logic             hs_err,
    output logic [15:0]      err_count
);
    logic [WIDTH-1:0] s, sx, ns, nsx, cv, cx, in_v, in_x, sep, viol, fly;
    logic [WIDTH-1:0] dv [STAGE_DELAY];
    logic [WIDTH-1:0] dx [STAGE_DELAY];
    logic [7:0]       cnt [WIDTH];
    logic [WIDTH-1:0] pd [RD_DELAY];
    logic [WIDTH-1:0] px [RD_DELAY];
    logic [RD_DELAY-1:0] pv;
    logic [16:0]      err_sum;

    // stage inputs, X propagation, carry generation and hold/setup window per stage
    always_comb begin
        in_v = WIDTH'({dv[STAGE_DELAY-1], t});
        in_x = WIDTH'({dx[STAGE_DELAY-1], 1'b0});
        fly = '0;
        for (int k = 0; k < STAGE_DELAY; k++) fly |= WIDTH'({dv[k], 1'b0});
        ns = s;
        nsx = sx;
        cv = '0;
        cx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sep[i] = in_v[i] && (cnt[i] < 8'(T_SEP));
            viol[i] = in_v[i] || (cnt[i] < 8'(HS_WIN)) || fly[i];
            if (in_v[i]) begin
                if (sx[i] || ((in_x[i] || sep[i]) && s[i])) begin
                    ns[i] = 1'b0;
                    nsx[i] = 1'b1;
                    cv[i] = 1'b1;
                    cx[i] = 1'b1;
                end else if (in_x[i] || sep[i]) begin
                    ns[i] = 1'b0;
                    nsx[i] = 1'b1;
                end else begin
                    ns[i] = ~s[i];
                    cv[i] = s[i];
                end
            end
        end
        sep_err = rst_n && |sep;
        hs_err = rst_n && wr0 && |viol;
        err_sum = {1'b0, err_count} + 17'(sep_err) + 17'(hs_err);
    end

    assign carry_out   = dv[STAGE_DELAY-1][WIDTH-1];
    assign carry_out_x = dx[STAGE_DELAY-1][WIDTH-1];
    assign rd1         = pd[RD_DELAY-1];
    assign rd1_x       = px[RD_DELAY-1];
    assign rd1_valid   = pv[RD_DELAY-1];

    // stage state, carry delay lines, spacing counters, readout pipeline and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= '0;
            sx <= '0;
            pv <= '0;
            err_count <= '0;
            for (int k = 0; k < STAGE_DELAY; k++) begin
                dv[k] <= '0;
                dx[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) cnt[i] <= 8'hFF;
            for (int k = 0; k < RD_DELAY; k++) begin
                pd[k] <= '0;
                px[k] <= '0;
            end
        end else begin
            s <= wr0 ? '0 : ns;
            sx <= wr0 ? viol : nsx;
            dv[0] <= cv;
            dx[0] <= cx;
            for (int k = 1; k < STAGE_DELAY; k++) begin
                dv[k] <= dv[k-1];
                dx[k] <= dx[k-1];
            end
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= in_v[i] ? 8'd1 : (cnt[i] == 8'hFF ? cnt[i] : cnt[i] + 8'd1);
            pv[0] <= wr0;
            pd[0] <= wr0 ? (s & ~sx & ~viol) : '0;
            px[0] <= wr0 ? (sx | viol) : '0;
            for (int k = 1; k < RD_DELAY; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
                px[k] <= px[k-1];
            end
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
endmodule
